// File: rtl/unidade_controle.sv
// Game control unit: Moore FSM sequencing the level-based puzzle game.
// A 26-bit timer limits each level's play time and then holds a pause
// after each level is solved.
//
// Ports:
//   clock                 - single clock, rising edge
//   reset                 - synchronous, active-high reset
//   iniciar               - start/restart request (level-sampled)
//   nivel_concluido       - datapath: current level solved
//   nivelIgualUltimoNivel - datapath: level counter is at the last level
//   contaN                - increment level counter
//   zeraN                 - clear level counter
//   zeraM                 - reset matrix, edge detectors and button register
//   pronto                - game ended
//   ganhou                - game won
//   perdeu                - game lost on timeout
//   db_estado             - current state encoding (debug)
module unidade_controle #(
  parameter int unsigned TEMPO_NIVEL = 50000000,
  parameter int unsigned TEMPO_PAUSA = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       nivel_concluido,
  input  logic       nivelIgualUltimoNivel,
  output logic       contaN,
  output logic       zeraN,
  output logic       zeraM,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    StInicial      = 3'd0,
    StPreparacao   = 3'd1,
    StCarregaNivel = 3'd2,
    StJogando      = 3'd3,
    StNivelOk      = 3'd4,
    StProximoNivel = 3'd5,
    StFimGanhou    = 3'd6,
    StFimPerdeu    = 3'd7
  } state_e;

  localparam logic [25:0] NivelFim = 26'(TEMPO_NIVEL - 1);
  localparam logic [25:0] PausaFim = 26'(TEMPO_PAUSA - 1);

  state_e      state_q, state_d;
  logic [25:0] timer_q, timer_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StInicial;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and timer logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StInicial: begin
        if (iniciar) state_d = StPreparacao;
      end
      StPreparacao: begin
        state_d = StCarregaNivel;
      end
      StCarregaNivel: begin
        timer_d = '0;
        state_d = StJogando;
      end
      StJogando: begin
        // Solving the level takes priority over the timeout in the same cycle.
        if (nivel_concluido) begin
          timer_d = '0;
          state_d = StNivelOk;
        end else begin
          timer_d = timer_q + 26'd1;
          if (timer_q == NivelFim) state_d = StFimPerdeu;
        end
      end
      StNivelOk: begin
        timer_d = timer_q + 26'd1;
        if (timer_q == PausaFim) begin
          state_d = nivelIgualUltimoNivel ? StFimGanhou : StProximoNivel;
        end
      end
      StProximoNivel: begin
        state_d = StCarregaNivel;
      end
      StFimGanhou, StFimPerdeu: begin
        if (iniciar) state_d = StPreparacao;
      end
      default: begin
        state_d = StInicial;
      end
    endcase
  end

  // Moore outputs: decoded from the state register only
  always_comb begin
    contaN = 1'b0;
    zeraN  = 1'b0;
    zeraM  = 1'b0;
    pronto = 1'b0;
    ganhou = 1'b0;
    perdeu = 1'b0;
    unique case (state_q)
      StPreparacao: begin
        zeraN = 1'b1;
        zeraM = 1'b1;
      end
      StCarregaNivel: zeraM = 1'b1;
      StProximoNivel: contaN = 1'b1;
      StFimGanhou: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      StFimPerdeu: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = {1'b0, state_q};

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with TEMPO_NIVEL=8, TEMPO_PAUSA=4.
module tb_unidade_controle;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       nivel_concluido;
  logic       nivelIgualUltimoNivel;
  logic       contaN, zeraN, zeraM, pronto, ganhou, perdeu;
  logic [3:0] db_estado;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  unidade_controle #(
    .TEMPO_NIVEL(8),
    .TEMPO_PAUSA(4)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .iniciar              (iniciar),
    .nivel_concluido      (nivel_concluido),
    .nivelIgualUltimoNivel(nivelIgualUltimoNivel),
    .contaN               (contaN),
    .zeraN                (zeraN),
    .zeraM                (zeraM),
    .pronto               (pronto),
    .ganhou               (ganhou),
    .perdeu               (perdeu),
    .db_estado            (db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected vector: {db_estado, contaN, zeraN, zeraM, pronto, ganhou, perdeu}
  task automatic chk(input string tag, input logic [3:0] st, input logic cn, input logic zn,
                     input logic zm, input logic pr, input logic gn, input logic pd);
    logic [9:0] obs, exp;
    obs = {db_estado, contaN, zeraN, zeraM, pronto, ganhou, perdeu};
    exp = {st, cn, zn, zm, pr, gn, pd};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed estado=%0d cN/zN/zM/pr/gn/pd=%b, expected estado=%0d %b",
                tag, obs[9:6], obs[5:0], exp[9:6], exp[5:0]);
  endtask

  task automatic chk_st(input string tag, input logic [3:0] st);
    unique case (st)
      4'd1:    chk(tag, st, 0, 1, 1, 0, 0, 0);
      4'd2:    chk(tag, st, 0, 0, 1, 0, 0, 0);
      4'd5:    chk(tag, st, 1, 0, 0, 0, 0, 0);
      4'd6:    chk(tag, st, 0, 0, 0, 1, 1, 0);
      4'd7:    chk(tag, st, 0, 0, 0, 1, 0, 1);
      default: chk(tag, st, 0, 0, 0, 0, 0, 0);
    endcase
  endtask

  initial begin
    reset = 1'b1;
    iniciar = 1'b0;
    nivel_concluido = 1'b0;
    nivelIgualUltimoNivel = 1'b0;

    // Reset and idle
    tick(); chk_st("reset", 4'd0);
    reset = 1'b0;
    tick(); chk_st("idle", 4'd0);
    tick(); chk_st("idle2", 4'd0);

    // Start sequence
    iniciar = 1'b1;
    tick(); chk_st("start_prep", 4'd1);
    iniciar = 1'b0;
    tick(); chk_st("start_carrega", 4'd2);
    tick(); chk_st("start_jog1", 4'd3);

    // Timeout: exactly 8 cycles of jogando
    for (int i = 2; i <= 8; i++) begin
      tick(); chk_st($sformatf("timeout_jog%0d", i), 4'd3);
    end
    tick(); chk_st("timeout_perdeu", 4'd7);
    tick(); chk_st("perdeu_hold1", 4'd7);
    tick(); chk_st("perdeu_hold2", 4'd7);

    // Restart and level advance
    iniciar = 1'b1;
    tick(); chk_st("restart_prep", 4'd1);
    iniciar = 1'b0;
    tick(); chk_st("restart_carrega", 4'd2);
    tick(); chk_st("adv_jog1", 4'd3);
    tick(); chk_st("adv_jog2", 4'd3);
    tick(); chk_st("adv_jog3", 4'd3);
    nivel_concluido = 1'b1;
    tick(); chk_st("adv_ok1", 4'd4);
    // nivel_concluido and iniciar must be ignored; last-level flag only counts at the end
    iniciar = 1'b1;
    nivelIgualUltimoNivel = 1'b1;
    tick(); chk_st("adv_ok2", 4'd4);
    tick(); chk_st("adv_ok3", 4'd4);
    nivelIgualUltimoNivel = 1'b0;
    tick(); chk_st("adv_ok4", 4'd4);
    nivel_concluido = 1'b0;
    tick(); chk_st("adv_proximo", 4'd5);
    tick(); chk_st("adv_carrega", 4'd2);
    iniciar = 1'b0;
    tick(); chk_st("win_jog1", 4'd3);

    // Win: level solved at once, last level at end of pause
    nivel_concluido = 1'b1;
    tick(); chk_st("win_ok1", 4'd4);
    nivel_concluido = 1'b0;
    nivelIgualUltimoNivel = 1'b1;
    tick(); chk_st("win_ok2", 4'd4);
    tick(); chk_st("win_ok3", 4'd4);
    tick(); chk_st("win_ok4", 4'd4);
    tick(); chk_st("win_ganhou", 4'd6);
    nivelIgualUltimoNivel = 1'b0;
    tick(); chk_st("ganhou_hold", 4'd6);

    // Simultaneous solve and timeout in the 8th jogando cycle
    iniciar = 1'b1;
    tick(); chk_st("sim_prep", 4'd1);
    iniciar = 1'b0;
    tick(); chk_st("sim_carrega", 4'd2);
    tick(); chk_st("sim_jog1", 4'd3);
    for (int i = 2; i <= 8; i++) begin
      tick(); chk_st($sformatf("sim_jog%0d", i), 4'd3);
    end
    nivel_concluido = 1'b1;
    tick(); chk_st("sim_nivel_ok", 4'd4);
    nivel_concluido = 1'b0;
    tick(); chk_st("sim_ok2", 4'd4);

    // Reset mid nivel_ok, with iniciar asserted to check priority
    reset = 1'b1;
    iniciar = 1'b1;
    tick(); chk_st("midreset", 4'd0);
    reset = 1'b0;
    iniciar = 1'b0;
    tick(); chk_st("midreset_idle", 4'd0);
    iniciar = 1'b1;
    tick(); chk_st("midreset_restart", 4'd1);
    iniciar = 1'b0;
    tick(); chk_st("midreset_carrega", 4'd2);
    tick(); chk_st("midreset_jog1", 4'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter TEMPO_NIVEL, default 50000000, the number of play cycles allowed per level (valid range 2..2^26-1).
REQ-002 The block SHALL have parameter TEMPO_PAUSA, default 25000000, the number of cycles to hold after a level is completed (valid range 2..2^26-1).

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port iniciar, input, 1, the start/restart request, level-sampled.
REQ-006 The block SHALL have port nivel_concluido, input, 1, from the datapath; the current level is solved.
REQ-007 The block SHALL have port nivelIgualUltimoNivel, input, 1, from the datapath; the level counter equals the last level.
REQ-008 The block SHALL have port contaN, output, 1, to the datapath; increments the level counter.
REQ-009 The block SHALL have port zeraN, output, 1, to the datapath; clears the level counter.
REQ-010 The block SHALL have port zeraM, output, 1, to the datapath; resets the matrix, the edge detectors and the button register.
REQ-011 The block SHALL have port pronto, output, 1, meaning the game has ended.
REQ-012 The block SHALL have port ganhou, output, 1, meaning the game was won.
REQ-013 The block SHALL have port perdeu, output, 1, meaning the game was lost on timeout.
REQ-014 The block SHALL have port db_estado, output, 4, the current state encoding, for debug.

Function
REQ-015 The block SHALL be a Moore FSM: every output SHALL be decoded only from the state register, so outputs are valid in the same cycle the state is entered.
REQ-016 The state encodings SHALL be: inicial=0, preparacao=1, carrega_nivel=2, jogando=3, nivel_ok=4, proximo_nivel=5, fim_ganhou=6, fim_perdeu=7; db_estado={1'b0,state}.
REQ-017 In inicial, all outputs SHALL be 0; if iniciar=1 the next state SHALL be preparacao, otherwise the state SHALL stay inicial.
REQ-018 In preparacao, zeraN=1 and zeraM=1 for exactly one cycle, then the next state SHALL be carrega_nivel.
REQ-019 In carrega_nivel, zeraM=1 for exactly one cycle; the timer SHALL load 0; the next state SHALL be jogando.
REQ-020 In jogando, the timer SHALL increment by 1 every cycle.
REQ-021 In jogando, if nivel_concluido=1, the next state SHALL be nivel_ok and the timer SHALL load 0.
REQ-022 In jogando, if nivel_concluido=0 and the timer equals TEMPO_NIVEL-1, the next state SHALL be fim_perdeu.
REQ-023 Consequence of REQ-020 to REQ-022: jogando SHALL last at most TEMPO_NIVEL cycles.
REQ-024 If nivel_concluido=1 and the timer equals TEMPO_NIVEL-1 in the same cycle, nivel_concluido SHALL win and the next state SHALL be nivel_ok.
REQ-025 In nivel_ok, the timer SHALL increment every cycle; when the timer equals TEMPO_PAUSA-1, the next state SHALL be fim_ganhou if nivelIgualUltimoNivel=1, else proximo_nivel.
REQ-026 In nivel_ok, nivelIgualUltimoNivel SHALL be sampled only in that final cycle, and nivel_concluido SHALL be ignored.
REQ-027 In proximo_nivel, contaN=1 for exactly one cycle, then the next state SHALL be carrega_nivel; contaN SHALL never be asserted in any other state.
REQ-028 In fim_ganhou, pronto=1 and ganhou=1; iniciar=1 SHALL move the state to preparacao, otherwise the state SHALL hold.
REQ-029 In fim_perdeu, pronto=1 and perdeu=1; iniciar=1 SHALL move the state to preparacao, otherwise the state SHALL hold.
REQ-030 iniciar SHALL be ignored in every state other than inicial, fim_ganhou and fim_perdeu.
REQ-031 The timer SHALL be 26 bits wide, unsigned, and SHALL never wrap in normal operation; it SHALL hold its value in inicial, fim_ganhou and fim_perdeu.
REQ-032 An unused encoding reached by any means SHALL transition to inicial on the next edge.

Reset
REQ-033 When reset=1 at a rising edge, the state SHALL become inicial and the timer SHALL become 0, regardless of the current state, including mid-jogando and mid-nivel_ok.
REQ-034 After reset, all outputs SHALL be 0 and db_estado SHALL be 0.
REQ-035 reset SHALL have priority over iniciar and every other input.

Verification (TEMPO_NIVEL=8, TEMPO_PAUSA=4)
REQ-036 Bench SHALL cover start: reset, then iniciar=1 at cycle k -> db_estado=1 at k+1 with zeraN=zeraM=1, db_estado=2 at k+2 with zeraM=1, db_estado=3 at k+3.
REQ-037 Bench SHALL cover timeout: nivel_concluido held 0 in jogando -> exactly 8 cycles of db_estado=3, then db_estado=7 with pronto=1 and perdeu=1, held until iniciar.
REQ-038 Bench SHALL cover the level advance: nivel_concluido=1 in the 3rd jogando cycle with nivelIgualUltimoNivel=0 -> 4 cycles of db_estado=4, then one cycle of db_estado=5 with contaN=1, then db_estado=2.
REQ-039 Bench SHALL cover the win: nivelIgualUltimoNivel=1 at the end of nivel_ok -> db_estado=6, pronto=1, ganhou=1, contaN never asserted.
REQ-040 Bench SHALL cover the simultaneous event: nivel_concluido=1 in the 8th jogando cycle -> db_estado=4, not 7.
REQ-041 Bench SHALL cover reset mid-operation: reset=1 during nivel_ok -> db_estado=0 on the next edge with all outputs 0; a subsequent iniciar restarts from preparacao.
